// File: rtl/auth_controller.sv
// Credential table and session lock controller: login/logout, password and user management, lockout timer.
// Latency: table hit at index j responds at acceptance+j+2, miss at +user_count+1, non-scan ops at +1.
// Backpressure: cmd_ready only in IDLE; one command in flight; no ready on rsp (single-cycle strobe).
module auth_controller #(
    parameter int MAX_USERS      = 8,
    parameter int DIGITS         = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter logic [DIGITS*DIGIT_W-1:0] ADMIN_USER = 16'h1100,
    parameter logic [DIGITS*DIGIT_W-1:0] ADMIN_PASS = 16'h1100
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [2:0]                         cmd_op,
    input  logic [DIGITS*DIGIT_W-1:0]          user_in,
    input  logic [DIGITS*DIGIT_W-1:0]          pass_in,
    input  logic [1:0]                         mode_in,
    output logic                               rsp_valid,
    output logic [2:0]                         rsp_status,
    output logic                               locked,
    output logic [1:0]                         cur_mode,
    output logic                               lockout,
    output logic [$clog2(MAX_USERS+1)-1:0]     user_count
);

    localparam int UW    = DIGITS * DIGIT_W;
    localparam int UC_W  = $clog2(MAX_USERS + 1);
    localparam int IDX_W = $clog2(MAX_USERS);
    localparam int FC_W  = $clog2(MAX_ATTEMPTS + 1);
    localparam int LC_W  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [2:0] OP_LOGIN    = 3'd0;
    localparam logic [2:0] OP_LOGOUT   = 3'd1;
    localparam logic [2:0] OP_SET_OWN  = 3'd2;
    localparam logic [2:0] OP_ADD_USER = 3'd3;
    localparam logic [2:0] OP_SET_PASS = 3'd4;
    localparam logic [2:0] OP_DEL_USER = 3'd5;

    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_BAD_CRED  = 3'd1;
    localparam logic [2:0] ST_LOCKOUT   = 3'd2;
    localparam logic [2:0] ST_DENIED    = 3'd3;
    localparam logic [2:0] ST_FULL      = 3'd4;
    localparam logic [2:0] ST_NOT_FOUND = 3'd5;
    localparam logic [2:0] ST_EXISTS    = 3'd6;
    localparam logic [2:0] ST_BAD_OP    = 3'd7;

    localparam logic [1:0] ROLE_ADMIN = 2'd0;
    localparam logic [1:0] ROLE_USER  = 2'd1;
    localparam logic [1:0] ROLE_GUEST = 2'd2;
    localparam logic [1:0] ROLE_NONE  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP, S_LOCK} state_t;

    state_t            state_q, state_d;
    logic [UW-1:0]     tbl_user_q [MAX_USERS];
    logic [UW-1:0]     tbl_user_d [MAX_USERS];
    logic [UW-1:0]     tbl_pass_q [MAX_USERS];
    logic [UW-1:0]     tbl_pass_d [MAX_USERS];
    logic [1:0]        tbl_role_q [MAX_USERS];
    logic [1:0]        tbl_role_d [MAX_USERS];
    logic [UC_W-1:0]   user_count_q, user_count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  sess_idx_q, sess_idx_d;
    logic [FC_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic              lock_trip_q, lock_trip_d;
    logic [2:0]        op_q, op_d;
    logic [UW-1:0]     cmd_user_q, cmd_user_d;
    logic [UW-1:0]     cmd_pass_q, cmd_pass_d;
    logic [1:0]        mode_q, mode_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [2:0]        rsp_status_q, rsp_status_d;
    logic              locked_q, locked_d;
    logic [1:0]        cur_mode_q, cur_mode_d;
    logic              lockout_q, lockout_d;

    logic [IDX_W-1:0]  last_idx;
    logic              hit;
    logic              last;

    assign last_idx = IDX_W'(user_count_q - UC_W'(1));
    assign hit      = (tbl_user_q[idx_q] == cmd_user_q);
    assign last     = (idx_q == last_idx);

    // Next-state: command decode, sequential table scan, op execution, lockout timer
    always_comb begin
        state_d      = state_q;
        tbl_user_d   = tbl_user_q;
        tbl_pass_d   = tbl_pass_q;
        tbl_role_d   = tbl_role_q;
        user_count_d = user_count_q;
        idx_d        = idx_q;
        sess_idx_d   = sess_idx_q;
        fail_cnt_d   = fail_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        lock_trip_d  = lock_trip_q;
        op_d         = op_q;
        cmd_user_d   = cmd_user_q;
        cmd_pass_d   = cmd_pass_q;
        mode_d       = mode_q;
        cmd_ready_d  = cmd_ready_q;
        rsp_valid_d  = 1'b0;
        rsp_status_d = rsp_status_q;
        locked_d     = locked_q;
        cur_mode_d   = cur_mode_q;
        lockout_d    = lockout_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = cmd_op;
                    cmd_user_d  = user_in;
                    cmd_pass_d  = pass_in;
                    mode_d      = mode_in;
                    idx_d       = '0;
                    cmd_ready_d = 1'b0;
                    // Default path is a direct response; scanning ops override below
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    case (cmd_op)
                        OP_LOGIN: begin
                            if (!locked_q) begin
                                rsp_status_d = ST_DENIED;
                            end else begin
                                state_d     = S_SCAN;
                                rsp_valid_d = 1'b0;
                            end
                        end
                        OP_LOGOUT: begin
                            if (locked_q) begin
                                rsp_status_d = ST_DENIED;
                            end else begin
                                rsp_status_d = ST_OK;
                                locked_d     = 1'b1;
                                cur_mode_d   = ROLE_NONE;
                                // Guest sessions are one-shot: drop the entry, backfill with the last one
                                if (cur_mode_q == ROLE_GUEST) begin
                                    tbl_user_d[sess_idx_q] = tbl_user_q[last_idx];
                                    tbl_pass_d[sess_idx_q] = tbl_pass_q[last_idx];
                                    tbl_role_d[sess_idx_q] = tbl_role_q[last_idx];
                                    user_count_d           = user_count_q - UC_W'(1);
                                end
                            end
                        end
                        OP_SET_OWN: begin
                            if (locked_q || cur_mode_q == ROLE_GUEST) begin
                                rsp_status_d = ST_DENIED;
                            end else begin
                                rsp_status_d           = ST_OK;
                                tbl_pass_d[sess_idx_q] = pass_in;
                            end
                        end
                        OP_ADD_USER, OP_SET_PASS, OP_DEL_USER: begin
                            if (locked_q || cur_mode_q != ROLE_ADMIN) begin
                                rsp_status_d = ST_DENIED;
                            end else begin
                                state_d     = S_SCAN;
                                rsp_valid_d = 1'b0;
                            end
                        end
                        default: rsp_status_d = ST_BAD_OP;
                    endcase
                end
            end

            S_SCAN: begin
                if (hit || last) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    case (op_q)
                        OP_LOGIN: begin
                            if (hit && tbl_pass_q[idx_q] == cmd_pass_q) begin
                                rsp_status_d = ST_OK;
                                locked_d     = 1'b0;
                                cur_mode_d   = tbl_role_q[idx_q];
                                sess_idx_d   = idx_q;
                                fail_cnt_d   = '0;
                            end else begin
                                fail_cnt_d = fail_cnt_q + FC_W'(1);
                                if (fail_cnt_d >= FC_W'(MAX_ATTEMPTS)) begin
                                    rsp_status_d = ST_LOCKOUT;
                                    lock_trip_d  = 1'b1;
                                end else begin
                                    rsp_status_d = ST_BAD_CRED;
                                end
                            end
                        end
                        OP_ADD_USER: begin
                            if (hit) begin
                                rsp_status_d = ST_EXISTS;
                            end else if (user_count_q == UC_W'(MAX_USERS)) begin
                                rsp_status_d = ST_FULL;
                            end else if (mode_q != ROLE_USER && mode_q != ROLE_GUEST) begin
                                rsp_status_d = ST_BAD_OP;
                            end else begin
                                rsp_status_d                      = ST_OK;
                                tbl_user_d[IDX_W'(user_count_q)]  = cmd_user_q;
                                tbl_pass_d[IDX_W'(user_count_q)]  = cmd_pass_q;
                                tbl_role_d[IDX_W'(user_count_q)]  = mode_q;
                                user_count_d                      = user_count_q + UC_W'(1);
                            end
                        end
                        OP_SET_PASS: begin
                            if (hit) begin
                                rsp_status_d      = ST_OK;
                                tbl_pass_d[idx_q] = cmd_pass_q;
                            end else begin
                                rsp_status_d = ST_NOT_FOUND;
                            end
                        end
                        OP_DEL_USER: begin
                            if (!hit) begin
                                rsp_status_d = ST_NOT_FOUND;
                            end else if (idx_q == '0 || idx_q == sess_idx_q) begin
                                rsp_status_d = ST_DENIED;
                            end else begin
                                rsp_status_d      = ST_OK;
                                tbl_user_d[idx_q] = tbl_user_q[last_idx];
                                tbl_pass_d[idx_q] = tbl_pass_q[last_idx];
                                tbl_role_d[idx_q] = tbl_role_q[last_idx];
                                user_count_d      = user_count_q - UC_W'(1);
                                // Keep the session pointing at its entry if that entry was the one moved
                                if (sess_idx_q == last_idx) begin
                                    sess_idx_d = idx_q;
                                end
                            end
                        end
                        default: rsp_status_d = ST_BAD_OP;
                    endcase
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_RESP: begin
                if (lock_trip_q) begin
                    state_d     = S_LOCK;
                    lock_trip_d = 1'b0;
                    lock_cnt_d  = '0;
                    lockout_d   = 1'b1;
                end else begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                end
            end

            S_LOCK: begin
                lock_cnt_d = lock_cnt_q + LC_W'(1);
                if (lock_cnt_q == LC_W'(LOCKOUT_CYCLES - 1)) begin
                    state_d     = S_IDLE;
                    lockout_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    fail_cnt_d  = '0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State and table registers; reset leaves only the admin entry and no session
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < MAX_USERS; i++) begin
                tbl_user_q[i] <= '0;
                tbl_pass_q[i] <= '0;
                tbl_role_q[i] <= ROLE_NONE;
            end
            tbl_user_q[0] <= ADMIN_USER;
            tbl_pass_q[0] <= ADMIN_PASS;
            tbl_role_q[0] <= ROLE_ADMIN;
            user_count_q  <= UC_W'(1);
            idx_q         <= '0;
            sess_idx_q    <= '0;
            fail_cnt_q    <= '0;
            lock_cnt_q    <= '0;
            lock_trip_q   <= 1'b0;
            op_q          <= '0;
            cmd_user_q    <= '0;
            cmd_pass_q    <= '0;
            mode_q        <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= ST_OK;
            locked_q      <= 1'b1;
            cur_mode_q    <= ROLE_NONE;
            lockout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tbl_user_q    <= tbl_user_d;
            tbl_pass_q    <= tbl_pass_d;
            tbl_role_q    <= tbl_role_d;
            user_count_q  <= user_count_d;
            idx_q         <= idx_d;
            sess_idx_q    <= sess_idx_d;
            fail_cnt_q    <= fail_cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            lock_trip_q   <= lock_trip_d;
            op_q          <= op_d;
            cmd_user_q    <= cmd_user_d;
            cmd_pass_q    <= cmd_pass_d;
            mode_q        <= mode_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            locked_q      <= locked_d;
            cur_mode_q    <= cur_mode_d;
            lockout_q     <= lockout_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign locked     = locked_q;
    assign cur_mode   = cur_mode_q;
    assign lockout    = lockout_q;
    assign user_count = user_count_q;

endmodule

// File: tb/tb_auth_controller.sv
// Directed bench for auth_controller: session flow, table management, lockout timing, mid-scan reset.
// Latency: checks response latency of every command against hand-computed values.
// Backpressure: waits (bounded) on cmd_ready before each command.
module tb_auth_controller;

    localparam int LC = 1000;

    localparam logic [2:0] LOGIN = 3'd0, LOGOUT = 3'd1, SET_OWN = 3'd2,
                           ADD = 3'd3, SET_PASS = 3'd4, DEL = 3'd5;
    localparam logic [2:0] OK = 3'd0, BAD_CRED = 3'd1, LOCKOUT_ST = 3'd2, DENIED = 3'd3,
                           FULL = 3'd4, NOT_FOUND = 3'd5, EXISTS = 3'd6, BAD_OP = 3'd7;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] user_in;
    logic [15:0] pass_in;
    logic [1:0]  mode_in;
    logic        rsp_valid;
    logic [2:0]  rsp_status;
    logic        locked;
    logic [1:0]  cur_mode;
    logic        lockout;
    logic [3:0]  user_count;

    int n_checks;
    int n_errors;

    auth_controller dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .user_in    (user_in),
        .pass_in    (pass_in),
        .mode_in    (mode_in),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .locked     (locked),
        .cur_mode   (cur_mode),
        .lockout    (lockout),
        .user_count (user_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command from a negedge; return status and cycles from acceptance to rsp_valid
    task automatic do_cmd(input logic [2:0] op, input logic [15:0] u, input logic [15:0] p,
                          input logic [1:0] m, output logic [2:0] st, output int lat);
        int   w;
        logic found;
        w = 0;
        while (!cmd_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_op    = op;
        user_in   = u;
        pass_in   = p;
        mode_in   = m;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat   = 0;
        st    = 3'd0;
        found = 1'b0;
        while (!found && lat < 50) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                found = 1'b1;
                st    = rsp_status;
            end
        end
        chk("rsp_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic exp_cmd(input string tag, input logic [2:0] op, input logic [15:0] u,
                           input logic [15:0] p, input logic [1:0] m,
                           input logic [2:0] exp_st, input int exp_lat);
        logic [2:0] st;
        int         lat;
        do_cmd(op, u, p, m, st, lat);
        chk({tag, "_status"}, {29'd0, st}, {29'd0, exp_st});
        if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        int n_lock;
        int n_rdy;
        int n_rsp;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        user_in   = 16'h0;
        pass_in   = 16'h0;
        mode_in   = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_locked",     {31'd0, locked},     32'd1);
        chk("rst_cur_mode",   {30'd0, cur_mode},   32'd3);
        chk("rst_lockout",    {31'd0, lockout},    32'd0);
        chk("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        chk("rst_rsp_status", {29'd0, rsp_status}, 32'd0);
        chk("rst_cmd_ready",  {31'd0, cmd_ready},  32'd1);
        chk("rst_user_count", {28'd0, user_count}, 32'd1);

        // Admin login: hit at index 0
        exp_cmd("login_admin", LOGIN, 16'h1100, 16'h1100, 2'd0, OK, 2);
        chk("login_admin_locked", {31'd0, locked}, 32'd0);
        chk("login_admin_mode", {30'd0, cur_mode}, 32'd0);
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);

        // Guest lifecycle
        exp_cmd("add_guest", ADD, 16'h2222, 16'h3333, 2'd2, OK, 2);
        chk("add_guest_count", {28'd0, user_count}, 32'd2);
        exp_cmd("logout_admin", LOGOUT, 16'h0, 16'h0, 2'd0, OK, 1);
        chk("logout_locked", {31'd0, locked}, 32'd1);
        chk("logout_mode", {30'd0, cur_mode}, 32'd3);
        exp_cmd("login_guest", LOGIN, 16'h2222, 16'h3333, 2'd0, OK, 3);
        chk("guest_mode", {30'd0, cur_mode}, 32'd2);
        exp_cmd("logout_guest", LOGOUT, 16'h0, 16'h0, 2'd0, OK, 1);
        chk("guest_removed_count", {28'd0, user_count}, 32'd1);

        // Failed logins leading to lockout
        exp_cmd("bad_login1", LOGIN, 16'h1100, 16'h0000, 2'd0, BAD_CRED, 2);
        exp_cmd("bad_login2", LOGIN, 16'h1100, 16'h0000, 2'd0, BAD_CRED, 2);
        exp_cmd("bad_login3", LOGIN, 16'h1100, 16'h0000, 2'd0, LOCKOUT_ST, 2);
        n_lock = 0;
        n_rdy  = 0;
        for (int c = 0; c < LC + 20; c++) begin
            @(negedge clk);
            if (lockout) begin
                n_lock++;
                if (cmd_ready) n_rdy++;
            end
        end
        chk("lockout_cycles", n_lock, LC);
        chk("ready_during_lockout", n_rdy, 0);
        exp_cmd("login_after_lock", LOGIN, 16'h1100, 16'h1100, 2'd0, OK, 2);

        // Fill the table; miss latency grows with user_count
        for (int k = 1; k <= 7; k++) begin
            exp_cmd("add_fill", ADD, 16'(16'h3000 + k), 16'h7777, 2'd1, OK, k + 1);
        end
        chk("full_count", {28'd0, user_count}, 32'd8);
        exp_cmd("add_full", ADD, 16'h4444, 16'h7777, 2'd1, FULL, 9);
        chk("full_count_kept", {28'd0, user_count}, 32'd8);
        exp_cmd("add_exists", ADD, 16'h1100, 16'h7777, 2'd1, EXISTS, 2);

        // Trim back to indexes 1..3, then swap-delete index 1
        for (int k = 7; k >= 4; k--) begin
            exp_cmd("del_tail", DEL, 16'(16'h3000 + k), 16'h0, 2'd0, OK, k + 2);
        end
        chk("trim_count", {28'd0, user_count}, 32'd4);
        exp_cmd("del_idx1", DEL, 16'h3001, 16'h0, 2'd0, OK, 3);
        chk("del_idx1_count", {28'd0, user_count}, 32'd3);
        exp_cmd("del_admin", DEL, 16'h1100, 16'h0, 2'd0, DENIED, 2);
        exp_cmd("del_missing", DEL, 16'h9999, 16'h0, 2'd0, NOT_FOUND, 4);
        exp_cmd("set_pass", SET_PASS, 16'h3002, 16'h8888, 2'd0, OK, 4);
        exp_cmd("set_pass_missing", SET_PASS, 16'h9999, 16'h8888, 2'd0, NOT_FOUND, 4);
        exp_cmd("reserved6", 3'd6, 16'h0, 16'h0, 2'd0, BAD_OP, 1);
        exp_cmd("reserved7", 3'd7, 16'h0, 16'h0, 2'd0, BAD_OP, 1);
        exp_cmd("add_mode0", ADD, 16'h4444, 16'h0, 2'd0, BAD_OP, 4);
        exp_cmd("add_mode3", ADD, 16'h4444, 16'h0, 2'd3, BAD_OP, 4);
        chk("bad_mode_count", {28'd0, user_count}, 32'd3);
        exp_cmd("login_unlocked", LOGIN, 16'h1100, 16'h1100, 2'd0, DENIED, 0);
        exp_cmd("logout2", LOGOUT, 16'h0, 16'h0, 2'd0, OK, 1);
        exp_cmd("logout_locked", LOGOUT, 16'h0, 16'h0, 2'd0, DENIED, 1);
        exp_cmd("setown_locked", SET_OWN, 16'h0, 16'h1234, 2'd0, DENIED, 1);

        // Moved entry still logs in; regular user permissions
        exp_cmd("login_moved", LOGIN, 16'h3003, 16'h7777, 2'd0, OK, 3);
        chk("user_mode", {30'd0, cur_mode}, 32'd1);
        exp_cmd("set_own", SET_OWN, 16'h0, 16'h1234, 2'd0, OK, 1);
        exp_cmd("add_as_user", ADD, 16'h5555, 16'h0, 2'd1, DENIED, 1);
        exp_cmd("logout3", LOGOUT, 16'h0, 16'h0, 2'd0, OK, 1);
        exp_cmd("login_new_own", LOGIN, 16'h3003, 16'h1234, 2'd0, OK, 3);
        exp_cmd("logout4", LOGOUT, 16'h0, 16'h0, 2'd0, OK, 1);
        exp_cmd("login_set_pass", LOGIN, 16'h3002, 16'h8888, 2'd0, OK, 4);
        exp_cmd("logout5", LOGOUT, 16'h0, 16'h0, 2'd0, OK, 1);

        // Reset in the middle of a scan
        @(negedge clk);
        cmd_op    = LOGIN;
        user_in   = 16'h9999;
        pass_in   = 16'h0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_rsp = 0;
        @(negedge clk);
        if (rsp_valid) n_rsp++;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        chk("midscan_no_rsp", n_rsp, 0);
        chk("midscan_count", {28'd0, user_count}, 32'd1);
        chk("midscan_locked", {31'd0, locked}, 32'd1);
        chk("midscan_ready", {31'd0, cmd_ready}, 32'd1);
        exp_cmd("post_rst_gone", LOGIN, 16'h3002, 16'h8888, 2'd0, BAD_CRED, 2);
        exp_cmd("post_rst_admin", LOGIN, 16'h1100, 16'h1100, 2'd0, OK, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/auth_controller.md
Name: auth_controller

Overview:
- Parametrised credential table and session lock controller, successor to the 8-entry/4-digit unlocker.
- Sits between the keypad digit collector and the lock actuator/status display.
- Accepts one command at a time over a valid/ready handshake and scans the table sequentially, one entry per cycle.
- Returns a single-cycle status response and enforces a timed lockout after repeated failed logins.

Parameters:
- MAX_USERS, 8, table depth (2..16); entry 0 is the permanent admin.
- DIGITS, 4, digits per username and per password.
- DIGIT_W, 4, bits per digit.
- MAX_ATTEMPTS, 3, consecutive failed logins that trigger lockout.
- LOCKOUT_CYCLES, 1000, lockout duration in clk cycles.
- ADMIN_USER, 16'h1100, reset username of entry 0 (width DIGITS*DIGIT_W).
- ADMIN_PASS, 16'h1100, reset password of entry 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  0 LOGIN, 1 LOGOUT, 2 SET_OWN_PASS, 3 ADD_USER, 4 SET_PASS, 5 DEL_USER, 6/7 reserved.
- user_in  in  DIGITS*DIGIT_W  username; digit 0 in the LSBs.
- pass_in  in  DIGITS*DIGIT_W  password or new password.
- mode_in  in  2  ADD_USER role: 1 user, 2 guest; 0 and 3 are rejected.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_status  out  3  0 OK, 1 BAD_CRED, 2 LOCKOUT, 3 DENIED, 4 FULL, 5 NOT_FOUND, 6 EXISTS, 7 BAD_OP.
- locked  out  1  1 = no active session.
- cur_mode  out  2  role of the logged-in user (0 admin, 1 user, 2 guest); 3 when locked.
- lockout  out  1  lockout timer running.
- user_count  out  $clog2(MAX_USERS+1)  valid entries.

Behaviour:
- Reset values:
  - Table: entry 0 = {ADMIN_USER, ADMIN_PASS, admin}; user_count = 1.
  - Outputs: locked = 1, cur_mode = 3, lockout = 0, rsp_valid = 0, rsp_status = 0, cmd_ready = 1.
  - Internal: fail_cnt = 0.
- Reset mid-scan or mid-lockout aborts the operation; no response is issued.
- Handshake:
  - A command is accepted on a cycle where cmd_valid & cmd_ready; inputs are sampled only in that cycle.
  - cmd_ready = 1 only in IDLE.
- FSM states: IDLE, SCAN, RESP, LOCK.
  - IDLE -> SCAN for LOGIN, ADD_USER, SET_PASS, DEL_USER. idx starts at 0.
  - IDLE -> RESP for LOGOUT, SET_OWN_PASS and reserved ops.
  - SCAN compares user_in against entry idx each cycle.
    - On a match, or when idx = user_count-1, the op executes and the FSM goes to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then IDLE. LOGIN that trips lockout instead goes RESP -> LOCK.
  - LOCK counts LOCKOUT_CYCLES cycles with lockout = 1, then clears fail_cnt and returns to IDLE.
- Latency:
  - Match at index j: rsp_valid at acceptance cycle + j + 2.
  - Miss: rsp_valid at acceptance + user_count + 1.
  - Non-scan ops: rsp_valid at acceptance + 1.
- Permission checks:
  - When locked, every op except LOGIN returns DENIED.
  - LOGIN while already unlocked returns DENIED.
  - ADD_USER, SET_PASS and DEL_USER require admin; otherwise DENIED with no scan (response at +1).
  - SET_OWN_PASS by a guest returns DENIED.
- Op results:
  - LOGIN, match with equal password: OK, locked = 0, session index stored, fail_cnt = 0.
  - LOGIN, mismatch or unknown user: fail_cnt + 1.
    - Status is BAD_CRED, or LOCKOUT when fail_cnt reaches MAX_ATTEMPTS.
  - LOGOUT: OK, locked = 1, cur_mode = 3.
    - If the session is a guest, its entry is removed: last entry moved into its slot, user_count - 1, updated in the same cycle.
  - SET_OWN_PASS: overwrites the password of the session entry; OK.
  - ADD_USER:
    - Match: EXISTS.
    - Miss and user_count = MAX_USERS: FULL.
    - Bad mode_in: BAD_OP.
    - Otherwise append at index user_count, user_count + 1, OK.
  - SET_PASS: match -> password overwritten, OK; miss -> NOT_FOUND.
  - DEL_USER:
    - Match at index 0 or at the session index: DENIED.
    - Other match: swap-with-last delete, OK.
    - Miss: NOT_FOUND.
  - Reserved ops: BAD_OP.
- Table writes and user_count updates take effect in the RESP cycle and are visible to the next command.
- cur_mode tracks the session entry; it is unaffected by swap deletes because the session index is remapped if the moved entry is the session entry.

Test Plan:
- Reset, then LOGIN user 16'h1100 / pass 16'h1100 -> rsp_valid at acceptance + 2, status 0, locked = 0, cur_mode = 0.
- As admin: ADD_USER 16'h2222 / 16'h3333 with mode_in = 2 -> OK, user_count = 2. LOGOUT, then LOGIN as 16'h2222 -> OK, cur_mode = 2. LOGOUT -> user_count = 1.
- Three LOGINs with 16'h1100 / 16'h0000 -> statuses 1, 1, 2.
  - lockout = 1 and cmd_ready = 0 for exactly LOCKOUT_CYCLES cycles.
  - Then a correct LOGIN returns OK.
- As admin, fill the table to MAX_USERS = 8, then ADD_USER a new name -> FULL, user_count stays 8. ADD_USER 16'h1100 -> EXISTS.
- With users at indexes 1..3: DEL_USER the index 1 user -> OK, the former index 3 entry moves to index 1 and is still loginable. DEL_USER 16'h1100 -> DENIED.
- Assert rst during a SCAN -> no rsp_valid; table back to admin only; user_count = 1, locked = 1.
